// File: rtl/sipo_word_assembler.sv
// ---------------------------------------------------------------------------
// sipo_word_assembler
//
// Purpose:
//   Collects a serial bit stream into WIDTH-bit words and presents each
//   completed word on a parallel valid/ready port. The output slot is
//   separate from the shift register, so serial intake keeps running while a
//   finished word waits for the downstream parallel-load stage.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  0: first accepted bit lands in p_data_o[0]
//              1: first accepted bit lands in p_data_o[WIDTH-1]
//
// Ports:
//   clk_i        single clock, all state changes on its rising edge
//   reset_i      synchronous active-high reset, wins over every other event
//   s_bit_i      serial data bit
//   s_valid_i    s_bit_i is valid this cycle
//   s_last_i     marks s_bit_i as the final bit of a frame
//   s_ready_o    bit is taken when s_valid_i && s_ready_o
//   p_data_o     assembled word
//   p_valid_o    p_data_o holds a word not yet consumed
//   p_ready_i    downstream takes the word when p_valid_o && p_ready_i
//   frame_err_o  one-cycle pulse when a frame ends before a full word
// ---------------------------------------------------------------------------
module sipo_word_assembler #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             s_bit_i,
  input  logic             s_valid_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] p_data_o,
  output logic             p_valid_o,
  input  logic             p_ready_i,
  output logic             frame_err_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

  // The output slot is either waiting for a word or holding one.
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } outState_e;

  outState_e        outState_q, outState_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [WIDTH-1:0] pData_q, pData_d;
  logic             frameErr_q, frameErr_d;

  logic             sReady;
  logic             acc;
  logic             wordDone;
  logic [CW-1:0]    bitPos;
  logic [WIDTH-1:0] merged;

  // Only the final bit of a word can be stalled: it needs the output slot,
  // and the slot is free if empty or being drained this very cycle. Depends
  // on p_ready_i but never on s_valid_i.
  always_comb begin
    sReady   = !((cnt_q == LastIdx) && (outState_q == HOLD) && !p_ready_i);
    acc      = s_valid_i && sReady;
    wordDone = acc && (cnt_q == LastIdx);
    bitPos   = MSB_FIRST ? (LastIdx - cnt_q) : cnt_q;
    merged   = shiftReg_q;
    merged[bitPos] = s_bit_i;
  end

  // Next-state logic for the bit counter, shift register, output slot and
  // error pulse. A completing word may load into a slot that is drained in
  // the same cycle, keeping p_valid high with no bubble. An early s_last
  // only resets the counter; stale bits left in the shift register are
  // overwritten position by position before the next word can complete.
  always_comb begin
    cnt_d      = cnt_q;
    shiftReg_d = shiftReg_q;
    pData_d    = pData_q;
    outState_d = outState_q;
    frameErr_d = 1'b0;

    if (acc) begin
      if (cnt_q == LastIdx) begin
        pData_d = merged;
        cnt_d   = '0;
      end else if (s_last_i) begin
        cnt_d      = '0;
        frameErr_d = 1'b1;
      end else begin
        shiftReg_d = merged;
        cnt_d      = cnt_q + CW'(1);
      end
    end

    case (outState_q)
      EMPTY: begin
        if (wordDone) outState_d = HOLD;
      end
      HOLD: begin
        if (p_ready_i && !wordDone) outState_d = EMPTY;
      end
      default: outState_d = EMPTY;
    endcase
  end

  // State registers with synchronous reset that discards both the partial
  // word and any word still waiting in the output slot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      shiftReg_q <= '0;
      pData_q    <= '0;
      outState_q <= EMPTY;
      frameErr_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shiftReg_q <= shiftReg_d;
      pData_q    <= pData_d;
      outState_q <= outState_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign s_ready_o   = sReady;
  assign p_data_o    = pData_q;
  assign p_valid_o   = (outState_q == HOLD);
  assign frame_err_o = frameErr_q;

endmodule

// File: tb/tb_sipo_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_sipo_word_assembler
//
// Drives two assemblers (LSB-first and MSB-first, WIDTH=4) with the same
// serial stream. A frame-level model (a queue of accepted bits, a pending
// flag and the last completed word) predicts the outputs, and a negedge
// process compares both DUTs with it every cycle. Directed sequences add
// literal expectations for the key scenarios.
// ---------------------------------------------------------------------------
module tb_sipo_word_assembler;

  logic       clk;
  logic       reset;
  logic       sBit;
  logic       sValid;
  logic       sLast;
  logic       pReady;

  logic       sReadyL, pValidL, frameErrL;
  logic [3:0] pDataL;
  logic       sReadyM, pValidM, frameErrM;
  logic [3:0] pDataM;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  sipo_word_assembler #(.WIDTH(4), .MSB_FIRST(1'b0)) dutLsb (
    .clk_i      (clk),
    .reset_i    (reset),
    .s_bit_i    (sBit),
    .s_valid_i  (sValid),
    .s_last_i   (sLast),
    .s_ready_o  (sReadyL),
    .p_data_o   (pDataL),
    .p_valid_o  (pValidL),
    .p_ready_i  (pReady),
    .frame_err_o(frameErrL)
  );

  sipo_word_assembler #(.WIDTH(4), .MSB_FIRST(1'b1)) dutMsb (
    .clk_i      (clk),
    .reset_i    (reset),
    .s_bit_i    (sBit),
    .s_valid_i  (sValid),
    .s_last_i   (sLast),
    .s_ready_o  (sReadyM),
    .p_data_o   (pDataM),
    .p_valid_o  (pValidM),
    .p_ready_i  (pReady),
    .frame_err_o(frameErrM)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model state.
  bit       mBits[$];
  bit       mHold  = 1'b0;
  bit       mErr   = 1'b0;
  bit [3:0] mDataL = 4'h0;
  bit [3:0] mDataM = 4'h0;

  // A single compare helper used by every check in the bench.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelReady();
    return !((mBits.size() == 3) && mHold && !pReady);
  endfunction

  // Model update: bits accumulate in a queue; the fourth accepted bit forms
  // a word in both bit orders, an early s_last throws the frame away.
  always @(posedge clk) begin
    bit acc;
    bit done;
    if (reset) begin
      mBits.delete();
      mHold  = 1'b0;
      mErr   = 1'b0;
      mDataL = 4'h0;
      mDataM = 4'h0;
    end else begin
      acc  = sValid && modelReady();
      done = 1'b0;
      mErr = 1'b0;
      if (acc) begin
        mBits.push_back(sBit);
        if (mBits.size() == 4) begin
          for (int i = 0; i < 4; i++) begin
            mDataL[i]     = mBits[i];
            mDataM[3 - i] = mBits[i];
          end
          mBits.delete();
          done = 1'b1;
        end else if (sLast) begin
          mBits.delete();
          mErr = 1'b1;
        end
      end
      if (done) mHold = 1'b1;
      else if (mHold && pReady) mHold = 1'b0;
    end
  end

  // Per-cycle comparison of both DUTs against the model, away from the
  // active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("s_ready lsb",   32'(sReadyL),   32'(modelReady()));
      checkOutput("s_ready msb",   32'(sReadyM),   32'(modelReady()));
      checkOutput("p_valid lsb",   32'(pValidL),   32'(mHold));
      checkOutput("p_valid msb",   32'(pValidM),   32'(mHold));
      checkOutput("p_data lsb",    32'(pDataL),    32'(mDataL));
      checkOutput("p_data msb",    32'(pDataM),    32'(mDataM));
      checkOutput("frame_err lsb", 32'(frameErrL), 32'(mErr));
      checkOutput("frame_err msb", 32'(frameErrM), 32'(mErr));
    end
  end

  // Drive one cycle of inputs, then return just after the edge that used
  // them so the caller sees the resulting registered outputs.
  task automatic applyStimulus(input logic b, input logic v, input logic l,
                               input logic pr);
    sBit   = b;
    sValid = v;
    sLast  = l;
    pReady = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBits(input logic [3:0] bits, input logic pr);
    for (int i = 0; i < 4; i++) applyStimulus(bits[i], 1'b1, 1'b0, pr);
  endtask

  initial begin
    bit gapBit;
    int gapLen;
    logic [3:0] gapBits;

    sBit   = 1'b0;
    sValid = 1'b0;
    sLast  = 1'b0;
    pReady = 1'b1;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset p_valid",   32'(pValidL),   32'd0);
    checkOutput("reset p_data",    32'(pDataL),    32'd0);
    checkOutput("reset frame_err", 32'(frameErrL), 32'd0);
    checkOutput("reset s_ready",   32'(sReadyL),   32'd1);

    // Bits 1,0,1,1 back-to-back with the downstream always ready.
    $display("[TB] back-to-back word, both bit orders");
    sendBits(4'b1101, 1'b1);
    checkOutput("t1 p_valid",     32'(pValidL),   32'd1);
    checkOutput("t1 p_data lsb",  32'(pDataL),    32'hD);
    checkOutput("t2 p_data msb",  32'(pDataM),    32'hB);
    checkOutput("t2 frame_err",   32'(frameErrM), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1 p_valid drop", 32'(pValidL),  32'd0);

    // Backpressure: 0xA then 0x5 with p_ready low.
    $display("[TB] backpressure with zero-bubble reload");
    sendBits(4'hA, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    sBit   = 1'b0;
    sValid = 1'b1;
    pReady = 1'b0;
    #1;
    checkOutput("t3 s_ready stalled", 32'(sReadyL), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("t3 hold data", 32'(pDataL), 32'hA);
    pReady = 1'b1;
    #1;
    checkOutput("t3 s_ready released", 32'(sReadyL), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("t3 reload valid", 32'(pValidL), 32'd1);
    checkOutput("t3 reload data",  32'(pDataL),  32'h5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3 drained", 32'(pValidL), 32'd0);

    // Short frame: s_last on the second bit.
    $display("[TB] short frame");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t4 frame_err pulse", 32'(frameErrL), 32'd1);
    checkOutput("t4 no p_valid",      32'(pValidL),   32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4 frame_err clear", 32'(frameErrL), 32'd0);
    sendBits(4'b0110, 1'b1);
    checkOutput("t4 next word", 32'(pDataL), 32'h6);

    // Reset with a word in HOLD and two bits buffered; bits keep arriving.
    $display("[TB] reset mid-stream");
    sendBits(4'b1100, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("t5 p_valid", 32'(pValidL), 32'd0);
    checkOutput("t5 p_data",  32'(pDataL),  32'd0);
    sendBits(4'hF, 1'b1);
    checkOutput("t5 word F", 32'(pDataL), 32'hF);

    // Random idle gaps with junk on s_bit/s_last between bits 1,1,0,0.
    $display("[TB] gapped stream");
    gapBits = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      gapLen = int'($urandom_range(0, 5));
      for (int g = 0; g < gapLen; g++) begin
        gapBit = 1'($urandom_range(0, 1));
        applyStimulus(gapBit, 1'b0, 1'b1, 1'b1);
      end
      applyStimulus(gapBits[i], 1'b1, 1'b0, 1'b1);
    end
    checkOutput("t6 p_valid",    32'(pValidL), 32'd1);
    checkOutput("t6 p_data lsb", 32'(pDataL),  32'h3);
    checkOutput("t6 p_data msb", 32'(pDataM),  32'hC);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
